prog_mem_ctrl: RTL and testbench



---
 rtl/prog_mem_ctrl_pkg.sv | 15 +
 rtl/prog_mem_ctrl_rr_arbiter.sv | 37 +++
 rtl/prog_mem_ctrl.sv | 115 +++++++++++
 tb/tb_prog_mem_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_mem_ctrl_pkg.sv
// rtl/prog_mem_ctrl_pkg.sv - shared FSM encoding and channel-index width helper
package prog_mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } mem_state_e;

   // A single channel still needs a 1-bit index so port widths never collapse to zero.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/prog_mem_ctrl_rr_arbiter.sv
// rtl/prog_mem_ctrl_rr_arbiter.sv - round-robin arbiter scanning from rr_ptr upward
module prog_mem_ctrl_rr_arbiter
   import prog_mem_ctrl_pkg::*;
#(
   parameter int NUM_CHANNELS = 4,
   parameter int CH_W         = ch_width(NUM_CHANNELS)
) (
   input  logic [NUM_CHANNELS-1:0] req,
   input  logic [CH_W-1:0]         rr_ptr,
   input  logic                    enable,
   output logic [NUM_CHANNELS-1:0] grant,
   output logic [CH_W-1:0]         grant_idx
);

   int              scan;
   logic [CH_W-1:0] scan_idx;
   logic            found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      scan      = 0;
      scan_idx  = '0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         scan = int'(rr_ptr) + k;
         if (scan >= NUM_CHANNELS) scan = scan - NUM_CHANNELS;
         scan_idx = CH_W'(scan);
         if (enable && !found && req[scan_idx]) begin
            grant[scan_idx] = 1'b1;
            grant_idx       = scan_idx;
            found           = 1'b1;
         end
      end
   end

endmodule

// File: rtl/prog_mem_ctrl.sv
// rtl/prog_mem_ctrl.sv - multi-channel instruction store with programmable read latency
module prog_mem_ctrl
   import prog_mem_ctrl_pkg::*;
#(
   parameter int PC_ADDR_WIDTH  = 8,
   parameter int INST_MSG_WIDTH = 16,
   parameter int NUM_CHANNELS   = 4,
   parameter int LATENCY        = 2
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_CHANNELS-1:0]               fetch_req_val,
   output logic [NUM_CHANNELS-1:0]               fetch_req_rdy,
   input  logic [NUM_CHANNELS*PC_ADDR_WIDTH-1:0] fetch_req_addr,
   output logic [NUM_CHANNELS-1:0]               fetch_resp_val,
   input  logic [NUM_CHANNELS-1:0]               fetch_resp_rdy,
   output logic [INST_MSG_WIDTH-1:0]             fetch_resp_inst,
   input  logic                                  load_en,
   input  logic [PC_ADDR_WIDTH-1:0]              load_addr,
   input  logic [INST_MSG_WIDTH-1:0]             load_data
);

   localparam int CH_W  = ch_width(NUM_CHANNELS);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int DEPTH = 1 << PC_ADDR_WIDTH;

   mem_state_e                state, state_n;
   logic [CH_W-1:0]           rr_ptr, ch_q, grant_idx;
   logic [CNT_W-1:0]          counter;
   logic [PC_ADDR_WIDTH-1:0]  addr_q;
   logic [NUM_CHANNELS-1:0]   grant;
   logic                      arb_en, req_fire, capture, resp_fire, resp_rdy_sel;
   logic [INST_MSG_WIDTH-1:0] store [DEPTH];

   prog_mem_ctrl_rr_arbiter #(
      .NUM_CHANNELS (NUM_CHANNELS),
      .CH_W         (CH_W)
   ) u_arb (
      .req       (fetch_req_val),
      .rr_ptr    (rr_ptr),
      .enable    (arb_en),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n        = state;
      arb_en         = 1'b0;
      req_fire       = 1'b0;
      capture        = 1'b0;
      resp_fire      = 1'b0;
      resp_rdy_sel   = 1'b0;
      fetch_req_rdy  = '0;
      fetch_resp_val = '0;
      for (int i = 0; i < NUM_CHANNELS; i++)
         if (CH_W'(i) == ch_q) resp_rdy_sel = fetch_resp_rdy[i];
      case (state)
         IDLE: begin
            // Gating with reset keeps rdy low while reset is held, not just after the edge.
            arb_en        = !load_en && reset;
            fetch_req_rdy = grant;
            if (|grant) begin
               req_fire = 1'b1;
               state_n  = BUSY;
            end
         end
         BUSY: begin
            if (counter == '0) begin
               capture = 1'b1;
               state_n = RESP;
            end
         end
         RESP: begin
            for (int i = 0; i < NUM_CHANNELS; i++)
               fetch_resp_val[i] = (CH_W'(i) == ch_q);
            if (resp_rdy_sel) begin
               resp_fire = 1'b1;
               state_n   = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr          <= '0;
         ch_q            <= '0;
         addr_q          <= '0;
         counter         <= '0;
         fetch_resp_inst <= '0;
      end else begin
         if (req_fire) begin
            ch_q    <= grant_idx;
            addr_q  <= fetch_req_addr[int'(grant_idx)*PC_ADDR_WIDTH +: PC_ADDR_WIDTH];
            counter <= CNT_W'(LATENCY - 1);
         end else if (state == BUSY && counter != '0) begin
            counter <= counter - 1'b1;
         end
         if (capture) fetch_resp_inst <= store[addr_q];
         if (resp_fire) rr_ptr <= (int'(ch_q) == NUM_CHANNELS - 1) ? '0 : ch_q + 1'b1;
      end
   end

   // Non-blocking write next to a non-blocking capture gives read-before-write on a collision.
   always_ff @(posedge clk) begin
      if (load_en) store[load_addr] <= load_data;
   end

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// tb/tb_prog_mem_ctrl.sv - randomized and directed checks of prog_mem_ctrl against a transaction model
module tb_prog_mem_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [3:0]  val0, rdy0, rval0, rrdy0;
   logic [31:0] addr0;
   logic [15:0] inst0;
   logic [0:0]  val1, rdy1, rval1, rrdy1;
   logic [7:0]  addr1;
   logic [15:0] inst1;
   logic        load_en;
   logic [7:0]  load_addr;
   logic [15:0] load_data;

   prog_mem_ctrl #(.PC_ADDR_WIDTH(8), .INST_MSG_WIDTH(16), .NUM_CHANNELS(4), .LATENCY(2)) dut (
      .clk(clk), .reset(reset),
      .fetch_req_val(val0), .fetch_req_rdy(rdy0), .fetch_req_addr(addr0),
      .fetch_resp_val(rval0), .fetch_resp_rdy(rrdy0), .fetch_resp_inst(inst0),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
   );

   prog_mem_ctrl #(.PC_ADDR_WIDTH(8), .INST_MSG_WIDTH(16), .NUM_CHANNELS(1), .LATENCY(1)) dut1 (
      .clk(clk), .reset(reset),
      .fetch_req_val(val1), .fetch_req_rdy(rdy1), .fetch_req_addr(addr1),
      .fetch_resp_val(rval1), .fetch_resp_rdy(rrdy1), .fetch_resp_inst(inst1),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
   );

   int          n_vec = 0;
   int          n_bad = 0;
   int          cyc   = 0;
   logic [15:0] mem [256];
   int          m_out [2];
   int          m_ch  [2];
   int          m_ths [2];
   int          m_ptr [2];
   logic [7:0]  m_addr [2];
   logic [15:0] m_word [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One fetch at a time; reply LATENCY+1 cycles after handshake with the word seen at capture.
   task automatic model_step(input int k);
      int          n, lat, g, idx;
      logic [3:0]  v, r, rv, rr, exp_rdy, exp_rval;
      logic [31:0] a;
      logic [15:0] ins;
      n   = (k == 0) ? 4 : 1;
      lat = (k == 0) ? 2 : 1;
      if (k == 0) begin
         v = val0; r = rdy0; rv = rval0; rr = rrdy0; a = addr0; ins = inst0;
      end else begin
         v = {3'b0, val1}; r = {3'b0, rdy1}; rv = {3'b0, rval1}; rr = {3'b0, rrdy1};
         a = {24'b0, addr1}; ins = inst1;
      end
      exp_rdy  = '0;
      exp_rval = '0;
      g        = -1;
      if (m_out[k] == 0 && !load_en)
         for (int s = 0; s < n; s++) begin
            idx = (m_ptr[k] + s) % n;
            if (g < 0 && v[idx]) g = idx;
         end
      if (g >= 0) exp_rdy[g] = 1'b1;
      if (m_out[k] != 0 && cyc >= m_ths[k] + lat + 1) exp_rval[m_ch[k]] = 1'b1;
      check($sformatf("req_rdy%0d", k), r, exp_rdy);
      check($sformatf("resp_val%0d", k), rv, exp_rval);
      check($sformatf("resp_inst%0d", k), ins, m_word[k]);
      if (g >= 0) begin
         m_out[k]  = 1;
         m_ch[k]   = g;
         m_addr[k] = a[g*8 +: 8];
         m_ths[k]  = cyc;
      end else if (m_out[k] != 0 && cyc == m_ths[k] + lat) begin
         m_word[k] = mem[m_addr[k]];
      end
      if (exp_rval != 0 && rr[m_ch[k]]) begin
         m_out[k] = 0;
         m_ptr[k] = (m_ch[k] + 1) % n;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_step(0);
      model_step(1);
      if (load_en) mem[load_addr] = load_data;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      check("rst_resp_val0", rval0, 0);
      check("rst_req_rdy0", rdy0, 0);
      check("rst_inst0", inst0, 0);
      check("rst_resp_val1", rval1, 0);
      check("rst_req_rdy1", rdy1, 0);
      for (int k = 0; k < 2; k++) begin
         m_out[k] = 0; m_ptr[k] = 0; m_word[k] = '0;
      end
      val0 = '0; val1 = '0; load_en = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_resp0(input int ch, input string tag);
      int k;
      k = 0;
      while (!rval0[ch] && k < 20) begin
         tick();
         k++;
      end
      check(tag, rval0[ch], 1);
   endtask

   initial begin
      int          k, cnt;
      logic [15:0] old_word;
      reset = 1'b1; val0 = 4'hF; addr0 = '0; rrdy0 = '0; val1 = 1'b1; addr1 = '0; rrdy1 = '0;
      load_en = 1'b0; load_addr = '0; load_data = '0;
      #2;
      do_reset();

      for (int a = 0; a < 256; a++) begin
         load_en = 1'b1; load_addr = 8'(a); load_data = 16'($urandom);
         tick();
      end
      load_addr = 8'h05; load_data = 16'hABCD;
      tick();
      load_en = 1'b0;

      // Single fetch latency on channel 0.
      val0 = 4'b0001; addr0 = 32'h0000_0005; rrdy0 = 4'hF;
      tick();
      val0 = '0;
      k = 1;
      while (!rval0[0] && k < 10) begin
         tick();
         k++;
      end
      check("t1_latency", k, 3);
      check("t1_inst", inst0, 16'hABCD);
      tick();
      check("t1_one_cycle", rval0, 0);

      // Three contending channels held high.
      val0 = 4'b1011; addr0 = 32'h0C_00_0A_03;
      for (int i = 0; i < 20; i++) tick();
      val0 = '0;
      for (int i = 0; i < 5; i++) tick();

      // Response backpressure on channel 2.
      val0 = 4'b0100; addr0 = 32'h0007_0000; rrdy0 = '0;
      tick();
      val0 = '0;
      wait_resp0(2, "t3_resp_seen");
      for (int i = 0; i < 5; i++) tick();
      rrdy0 = 4'b0100;
      tick();
      check("t3_released", rval0, 0);

      // Load blocks arbitration; then same-address write in the capture cycle.
      rrdy0 = 4'hF; load_en = 1'b1; load_addr = 8'h20; load_data = 16'h1234;
      val0 = 4'b0010; addr0 = 32'h0000_0900;
      for (int i = 0; i < 3; i++) tick();
      load_en = 1'b0;
      old_word = mem[8'h09];
      tick();
      val0 = '0;
      tick();
      load_en = 1'b1; load_addr = 8'h09; load_data = ~old_word;
      tick();
      load_en = 1'b0;
      wait_resp0(1, "t4_resp_seen");
      check("t4_old_word", inst0, {16'h0, old_word});

      // Reset during BUSY and during RESP.
      val0 = 4'b1000; addr0 = 32'h1100_0000; rrdy0 = '0;
      tick();
      val0 = '0;
      tick();
      do_reset();
      val0 = 4'b1000;
      tick();
      val0 = '0;
      wait_resp0(3, "t5_resp_seen");
      do_reset();
      rrdy0 = 4'hF; val0 = 4'b0001; addr0 = 32'h0000_0012;
      tick();
      val0 = '0;
      k = 1;
      while (!rval0[0] && k < 10) begin
         tick();
         k++;
      end
      check("t5_latency", k, 3);
      tick();

      // Single channel, LATENCY=1, back-to-back.
      val1 = 1'b1; rrdy1 = 1'b1; cnt = 0;
      for (int i = 0; i < 24; i++) begin
         addr1 = 8'($urandom);
         if (rval1[0]) cnt++;
         tick();
      end
      val1 = '0;
      check("n1_resp_count", cnt, 8);
      for (int i = 0; i < 4; i++) tick();

      for (int n = 0; n < 3000; n++) begin
         val0  = 4'($urandom);
         addr0 = $urandom & 32'h0F0F_0F0F;
         rrdy0 = 4'($urandom);
         val1  = 1'($urandom);
         addr1 = 8'($urandom_range(0, 15));
         rrdy1 = 1'($urandom);
         load_en   = ($urandom_range(0, 7) == 0);
         load_addr = 8'($urandom_range(0, 15));
         load_data = 16'($urandom);
         if ($urandom_range(0, 199) == 0) do_reset();
         else tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
